// File: rtl/cpu_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cpu_bus_master                                                  |
// | Purpose  : req/ack memory-bus master driven by the CPU I/O control state,  |
// |            with a per-transaction timeout and bus-error flag.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cpu_bus_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        io_state,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              bus_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack
);

  localparam logic [2:0] c_IO_READ_BEGIN  = 3'd1;
  localparam logic [2:0] c_IO_WRITE_BEGIN = 3'd3;

  localparam bit              c_TO_EN     = (TIMEOUT != 0);
  localparam int              c_CNT_W     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int              c_TO_LAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_TO_LAST);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = {c_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_bus_error, w_bus_error_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_bus_error <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rdata     <= w_rdata_nxt;
      r_ready     <= w_ready_nxt;
      r_bus_error <= w_bus_error_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rdata_nxt     = r_rdata;
    w_ready_nxt     = 1'b0;
    w_bus_error_nxt = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;

    case (r_state)
      S_IDLE: begin
        if (io_state == c_IO_READ_BEGIN || io_state == c_IO_WRITE_BEGIN) begin
          w_mem_addr_nxt = addr;
          w_mem_req_nxt  = 1'b1;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_REQ;
          if (io_state == c_IO_WRITE_BEGIN) begin
            w_mem_wdata_nxt = wdata;
            w_mem_we_nxt    = 1'b1;
          end else begin
            w_mem_we_nxt    = 1'b0;
          end
        end
      end

      S_REQ: begin
        // An ack arriving on the final timeout cycle still completes normally.
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_ready_nxt   = 1'b1;
          if (!r_mem_we) w_rdata_nxt = mem_rdata;
          w_state_nxt   = S_DONE;
        end else if (c_TO_EN && (r_cnt == c_CNT_LAST)) begin
          w_mem_req_nxt   = 1'b0;
          w_ready_nxt     = 1'b1;
          w_bus_error_nxt = 1'b1;
          if (!r_mem_we) w_rdata_nxt = {DATA_W{1'b1}};
          w_state_nxt     = S_DONE;
        end else if (r_cnt != c_CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  assign rdata     = r_rdata;
  assign ready     = r_ready;
  assign bus_error = r_bus_error;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cpu_bus_master                                               |
// | Purpose  : directed self-checking bench for cpu_bus_master (TIMEOUT = 4).  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cpu_bus_master;

  localparam logic [2:0] c_IO_IDLE        = 3'd0;
  localparam logic [2:0] c_IO_READ_BEGIN  = 3'd1;
  localparam logic [2:0] c_IO_READ_WAIT   = 3'd2;
  localparam logic [2:0] c_IO_WRITE_BEGIN = 3'd3;
  localparam logic [2:0] c_IO_WRITE_WAIT  = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  io_state;
  logic [15:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        ready, bus_error, mem_req, mem_we, mem_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  cpu_bus_master #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_state  (io_state),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .bus_error (bus_error),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; io_state = c_IO_IDLE; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    #3;
    check("rst_req",   mem_req,   0);
    check("rst_ready", ready,     0);
    check("rst_err",   bus_error, 0);
    check("rst_rdata", rdata,     0);
    check("rst_we",    mem_we,    0);
    check("rst_addr",  mem_addr,  0);
    tick();
    reset = 1'b0;
    tick();

    // 1: read, ack after one cycle
    io_state = c_IO_READ_BEGIN; addr = 16'h0010;
    tick();
    check("t1_req",   mem_req,  1);
    check("t1_we",    mem_we,   0);
    check("t1_addr",  mem_addr, 16'h0010);
    check("t1_rdy0",  ready,    0);
    io_state = c_IO_READ_WAIT; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    check("t1_req_dn", mem_req,   0);
    check("t1_ready",  ready,     1);
    check("t1_rdata",  rdata,     16'hBEEF);
    check("t1_err",    bus_error, 0);
    mem_ack = 1'b0; mem_rdata = 16'h0000; io_state = c_IO_IDLE;
    tick();
    check("t1_rdy_end", ready, 0);

    // 2: write 0100/1234, ack after 3 REQ cycles; bus must hold while inputs change
    io_state = c_IO_WRITE_BEGIN; addr = 16'h0100; wdata = 16'h1234;
    tick();
    io_state = c_IO_WRITE_WAIT; addr = 16'hDEAD; wdata = 16'hCAFE;
    for (int i = 0; i < 2; i++) begin
      check("t2_req",   mem_req,   1);
      check("t2_we",    mem_we,    1);
      check("t2_addr",  mem_addr,  16'h0100);
      check("t2_wdata", mem_wdata, 16'h1234);
      check("t2_rdy0",  ready,     0);
      tick();
    end
    check("t2_req3",   mem_req,   1);
    check("t2_addr3",  mem_addr,  16'h0100);
    check("t2_wdata3", mem_wdata, 16'h1234);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    check("t2_ready",  ready,     1);
    check("t2_req_dn", mem_req,   0);
    check("t2_err",    bus_error, 0);
    check("t2_rdata",  rdata,     16'hBEEF);
    mem_ack = 1'b0; io_state = c_IO_IDLE;
    tick();
    check("t2_rdy_end", ready, 0);

    // 3: read with no ack -> timeout after 4 REQ cycles
    io_state = c_IO_READ_BEGIN; addr = 16'h0020;
    tick();
    io_state = c_IO_READ_WAIT;
    for (int i = 0; i < 3; i++) begin
      check("t3_req",  mem_req, 1);
      check("t3_rdy0", ready,   0);
      tick();
    end
    check("t3_req4", mem_req, 1);
    tick();
    check("t3_req_dn", mem_req,   0);
    check("t3_ready",  ready,     1);
    check("t3_err",    bus_error, 1);
    check("t3_rdata",  rdata,     16'hFFFF);
    io_state = c_IO_IDLE;
    tick();
    check("t3_rdy_end", ready,     0);
    check("t3_err_end", bus_error, 0);

    // 4: ack on the 4th (timeout) REQ cycle wins
    io_state = c_IO_READ_BEGIN; addr = 16'h0030;
    tick();
    io_state = c_IO_READ_WAIT;
    tick(); tick(); tick();
    check("t4_req4", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    check("t4_ready", ready,     1);
    check("t4_err",   bus_error, 0);
    check("t4_rdata", rdata,     16'h5A5A);
    mem_ack = 1'b0; io_state = c_IO_IDLE;
    tick();

    // 5: asynchronous reset mid-REQ, then a clean read
    io_state = c_IO_READ_BEGIN; addr = 16'h0040;
    tick();
    io_state = c_IO_READ_WAIT;
    tick();
    check("t5_req_pre", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_req_rst",   mem_req, 0);
    check("t5_ready_rst", ready,   0);
    check("t5_rdata_rst", rdata,   0);
    #1 reset = 1'b0; io_state = c_IO_READ_BEGIN; addr = 16'h0050;
    tick();
    check("t5_req_new",  mem_req,  1);
    check("t5_addr_new", mem_addr, 16'h0050);
    io_state = c_IO_READ_WAIT; mem_ack = 1'b1; mem_rdata = 16'h1357;
    tick();
    check("t5_ready", ready, 1);
    check("t5_rdata", rdata, 16'h1357);
    mem_ack = 1'b0; io_state = c_IO_IDLE;
    tick();

    // 6: spurious ack in IDLE, then begin held through REQ and DONE
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    tick();
    check("t6_spur_rdy", ready,   0);
    check("t6_spur_req", mem_req, 0);
    check("t6_spur_rd",  rdata,   16'h1357);
    mem_ack = 1'b0;
    io_state = c_IO_READ_BEGIN; addr = 16'h0200;
    tick();
    check("t6_req", mem_req, 1);
    addr = 16'h0300;
    tick();
    check("t6_req_hold",  mem_req,  1);
    check("t6_addr_hold", mem_addr, 16'h0200);
    check("t6_rdy_hold",  ready,    0);
    mem_ack = 1'b1; mem_rdata = 16'h2468;
    tick();
    check("t6_ready", ready, 1);
    check("t6_rdata", rdata, 16'h2468);
    mem_ack = 1'b0;
    tick();
    check("t6_done_req", mem_req, 0);
    check("t6_done_rdy", ready,   0);
    io_state = c_IO_IDLE;
    tick();
    check("t6_idle_req", mem_req, 0);
    check("t6_idle_rdy", ready,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
